// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int WAIT_W = 16;
  localparam int CTRL_W = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } ctrl_state_e;

  // Control word loaded into a pipeline register when it takes a bubble.
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW hazard detection for the ID instruction.
// PIPELINE_CTRL_FORWARD_EN: forwarding present, only load-use stalls.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_dst,
  output logic             haz
);

  logic ex_rs, ex_rt;
  assign ex_rs = (ex_dst != '0) && (ex_dst == id_rs);
  assign ex_rt = (ex_dst != '0) && (ex_dst == id_rt) && id_uses_rt;

`ifdef PIPELINE_CTRL_FORWARD_EN
  logic unused_mem;
  assign unused_mem = ^{mem_regwrite, mem_dst};
  assign haz = ex_memread && ex_regwrite && (ex_rs || ex_rt);
`else
  // Register file writes in the first half-cycle, so WB never interlocks.
  logic mem_rs, mem_rt;
  logic unused_memread;
  assign unused_memread = ex_memread;
  assign mem_rs = (mem_dst != '0) && (mem_dst == id_rs);
  assign mem_rt = (mem_dst != '0) && (mem_dst == id_rt) && id_uses_rt;
  assign haz = (ex_regwrite && (ex_rs || ex_rt)) ||
               (mem_regwrite && (mem_rs || mem_rt));
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline controller: stall/flush/freeze enables, memory-wait FSM
// with timeout, stall-cycle counter. Hazard rule set by PIPELINE_CTRL_FORWARD_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic                   id_uses_rt,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic [REG_W-1:0]       ex_dst,
  input  logic                   mem_regwrite,
  input  logic [REG_W-1:0]       mem_dst,
  input  logic                   ex_branch_taken,
  input  logic                   ex_jump,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic [1:0]             ctrl_state,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_e             state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [STALL_CNT_W-1:0]  stall_q;
  logic [4:0]              en;
  logic                    haz, redirect, run_rules;

  hazard_detect u_haz (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_dst      (ex_dst),
    .mem_regwrite(mem_regwrite),
    .mem_dst     (mem_dst),
    .haz         (haz)
  );

  assign redirect = ex_branch_taken || ex_jump;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    en          = '1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    run_rules   = 1'b0;
    if (reset) begin
      en          = '0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            en      = '0;
            state_d = ST_MEM_WAIT;
            wait_d  = '0;
          end else begin
            run_rules = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // The wait counter counts cycles spent in MEM_WAIT itself.
          if (!mem_ready) begin
            en     = '0;
            wait_d = wait_q + WAIT_W'(1);
            if (wait_d == TMO) state_d = ST_HALT;
          end else begin
            state_d   = ST_RUN;
            run_rules = 1'b1;
          end
        end
        ST_HALT: en = '0;
        default: begin
          en      = '0;
          state_d = ST_RUN;
        end
      endcase
      if (run_rules) begin
        if (redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (haz) begin
          en[4:3]     = 2'b00;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!en[4] && (stall_q != '1)) stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
  assign ctrl_state  = state_q;
  assign mem_timeout = (state_q == ST_HALT);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [4:0]  en;   // pc, if_id, id_ex, ex_mem, mem_wb
    logic [1:0]  fl;   // if_id_flush, id_ex_flush
    logic [1:0]  st;
    logic        tmo;
    logic [15:0] sc;
  } exp_t;

  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] HAZ  = 5'b00111;
  localparam logic [1:0] RUN = 2'b00, MW = 2'b01, HLT = 2'b10;

`ifdef PIPELINE_CTRL_FORWARD_EN
  localparam logic [4:0] NOFWD_EN = ALL;
  localparam logic [1:0] NOFWD_FL = 2'b00;
`else
  localparam logic [4:0] NOFWD_EN = HAZ;
  localparam logic [1:0] NOFWD_FL = 2'b01;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic id_uses_rt, ex_regwrite, ex_memread, mem_regwrite;
  logic ex_branch_taken, ex_jump, mem_req, mem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_timeout;
  logic [1:0] ctrl_state;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  int sc_model = 0;
  exp_t exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_dst(ex_dst),
    .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ctrl_state(ctrl_state), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  task automatic idle();
    reset = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_dst = 0;
    mem_regwrite = 0; mem_dst = 0;
    ex_branch_taken = 0; ex_jump = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Inputs are already applied (just after a falling edge); push the
  // expectation, let the outputs settle, compare, then move to the next cycle.
  task automatic step(input string tag, input logic [4:0] en,
                      input logic [1:0] fl, input logic [1:0] st);
    exp_t e, got;
    e.en = en; e.fl = fl; e.st = st; e.tmo = (st == HLT); e.sc = 16'(sc_model);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    got = '{en: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
            fl: {if_id_flush, id_ex_flush}, st: ctrl_state,
            tmo: mem_timeout, sc: stall_count};
    e = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s got en=%b fl=%b st=%b tmo=%b sc=%0d exp en=%b fl=%b st=%b tmo=%b sc=%0d",
             tag, got.en, got.fl, got.st, got.tmo, got.sc,
             e.en, e.fl, e.st, e.tmo, e.sc);
    end
    if (reset) sc_model = 0;
    else if (!en[4]) sc_model++;
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    step("reset", NONE, 2'b11, RUN);
    idle();
    step("idle", ALL, 2'b00, RUN);

    // Load-use on rs: one bubble
    ex_memread = 1; ex_regwrite = 1; ex_dst = 8; id_rs = 8;
    step("load_use", HAZ, 2'b01, RUN);
    idle();
    step("after_load_use", ALL, 2'b00, RUN);

    ex_memread = 1; ex_regwrite = 1; ex_dst = 0; id_rs = 0;
    step("dst_zero", ALL, 2'b00, RUN);
    id_rs = 8;
    step("dst_zero_rs8", ALL, 2'b00, RUN);

    // rt only matters when the ID instruction reads it
    ex_dst = 5; id_rs = 1; id_rt = 5; id_uses_rt = 0;
    step("rt_unused", ALL, 2'b00, RUN);
    id_uses_rt = 1;
    step("rt_used", HAZ, 2'b01, RUN);

    // Redirect wins over the hazard
    ex_branch_taken = 1;
    step("branch_vs_haz", ALL, 2'b11, RUN);
    idle(); ex_jump = 1;
    step("jump", ALL, 2'b11, RUN);

    // Write-pending hazards only interlock without forwarding
    idle(); mem_regwrite = 1; mem_dst = 9; id_rt = 9; id_uses_rt = 1;
    step("nofwd_mem_rt", NOFWD_EN, NOFWD_FL, RUN);
    idle(); ex_regwrite = 1; ex_dst = 9; id_rs = 9;
    step("nofwd_ex_rs", NOFWD_EN, NOFWD_FL, RUN);

    // Memory wait: three frozen cycles, advance in the ready cycle
    idle(); mem_req = 1;
    step("mw_enter", NONE, 2'b00, RUN);
    step("mw_wait1", NONE, 2'b00, MW);
    step("mw_wait2", NONE, 2'b00, MW);
    mem_ready = 1;
    step("mw_ready", ALL, 2'b00, MW);
    idle();
    step("mw_after", ALL, 2'b00, RUN);

    // Ready cycle still subject to hazard rule
    mem_req = 1;
    step("mw2_enter", NONE, 2'b00, RUN);
    mem_ready = 1; ex_memread = 1; ex_regwrite = 1; ex_dst = 3; id_rs = 3;
    step("mw2_ready_haz", HAZ, 2'b01, MW);
    idle();
    step("mw2_after", ALL, 2'b00, RUN);

    // Reset in the middle of a wait
    mem_req = 1;
    step("mw3_enter", NONE, 2'b00, RUN);
    step("mw3_wait", NONE, 2'b00, MW);
    reset = 1;
    step("mw3_reset", NONE, 2'b11, MW);
    idle();
    step("mw3_after_reset", ALL, 2'b00, RUN);

    // Timeout after four MEM_WAIT cycles
    mem_req = 1;
    step("tmo_enter", NONE, 2'b00, RUN);
    for (int i = 0; i < 4; i++) step($sformatf("tmo_wait%0d", i), NONE, 2'b00, MW);
    step("tmo_halt", NONE, 2'b00, HLT);
    mem_ready = 1;
    step("tmo_halt_ready", NONE, 2'b00, HLT);
    idle();
    step("tmo_halt_idle", NONE, 2'b00, HLT);
    reset = 1;
    step("tmo_reset", NONE, 2'b11, HLT);
    idle();
    step("tmo_after_reset", ALL, 2'b00, RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
